frv_pipeline_mdu_stage: RTL and testbench

Consumer end of the dispatch→execute (s3) handshake: accepts the operand bundle issued by dispatch, holds it as the s4 pipeline register, and executes RV32M multiply/divide micro-ops on an iterative 1-bit-per-cycle datapath. Non-MDU instructions pass through in one cycle with operands intact for the downstream units. It asserts `s3_p_busy` to stall dispatch while an MDU op iterates or while s4 is back-pressured.

---
 rtl/frv_pipeline_mdu_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_frv_pipeline_mdu_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frv_pipeline_mdu_stage.sv
// Execute-stage s4 register: single-cycle pass-through, iterative RV32M multiply/divide.
// Latency: 1 edge for pass-through; 33 edges after accept for MDU ops.
// Backpressure: s3_p_busy stalls dispatch while iterating or while s4 is held by s4_p_busy.
module frv_pipeline_mdu_stage #(
   parameter int XLEN = 32
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            flush,
   input  logic            s3_p_valid,
   output logic            s3_p_busy,
   input  logic [4:0]      s3_rd,
   input  logic [XLEN-1:0] s3_opr_a,
   input  logic [XLEN-1:0] s3_opr_b,
   input  logic [XLEN-1:0] s3_opr_c,
   input  logic [31:0]     s3_pc,
   input  logic [4:0]      s3_uop,
   input  logic [4:0]      s3_fu,
   input  logic            s3_trap,
   input  logic [1:0]      s3_size,
   input  logic [31:0]     s3_instr,
   output logic            s4_p_valid,
   input  logic            s4_p_busy,
   output logic [4:0]      s4_rd,
   output logic [XLEN-1:0] s4_result,
   output logic [XLEN-1:0] s4_opr_b,
   output logic [XLEN-1:0] s4_opr_c,
   output logic [31:0]     s4_pc,
   output logic [4:0]      s4_uop,
   output logic [4:0]      s4_fu,
   output logic            s4_trap,
   output logic [1:0]      s4_size,
   output logic [31:0]     s4_instr
);

   localparam int XL = XLEN - 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t state, state_n;
   logic [4:0] counter;

   // Captured MDU sidebands, carried into s4 when the result is ready
   logic [4:0]      cap_rd;
   logic [XLEN-1:0] cap_b;
   logic [XLEN-1:0] cap_c;
   logic [31:0]     cap_pc;
   logic [4:0]      cap_uop;
   logic [4:0]      cap_fu;
   logic            cap_trap;
   logic [1:0]      cap_size;
   logic [31:0]     cap_instr;

   // Magnitude datapath and sign-correction flags
   logic [XLEN-1:0]   mag_b;
   logic [2*XLEN-1:0] acc;
   logic              prod_neg;
   logic              quo_neg;
   logic              rem_neg;

   logic            accept;
   logic            xfer_out;
   logic            is_mdu;
   logic            mdu_start;
   logic [2:0]      in_op;
   logic            sgn_a;
   logic            sgn_b;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] in_mag_a;
   logic [XLEN-1:0] in_mag_b;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_rs;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] acc_n;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   mdu_result;

   assign accept    = s3_p_valid && !s3_p_busy && !flush;
   assign xfer_out  = s4_p_valid && !s4_p_busy;
   assign is_mdu    = s3_fu[1] && !s3_trap;
   assign mdu_start = accept && is_mdu;
   assign s3_p_busy = (state != IDLE) || (s4_p_valid && s4_p_busy);

   // Operand signedness: MUL/MULH/DIV/REM signed both; MULHSU signed a only; *U unsigned
   assign in_op    = s3_uop[2:0];
   assign sgn_a    = (in_op != 3'd3) && (in_op != 3'd5) && (in_op != 3'd7);
   assign sgn_b    = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
   assign a_neg    = sgn_a && s3_opr_a[XL];
   assign b_neg    = sgn_b && s3_opr_b[XL];
   assign in_mag_a = a_neg ? -s3_opr_a : s3_opr_a;
   assign in_mag_b = b_neg ? -s3_opr_b : s3_opr_b;

   // One iteration step: shift-add multiply (multiplier in acc low half) or restoring divide
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
      div_rs  = acc[2*XLEN-1:XL];
      div_ge  = div_rs >= {1'b0, mag_b};
      div_rem = div_ge ? XLEN'(div_rs - {1'b0, mag_b}) : div_rs[XL:0];
      acc_n   = acc;
      if (state == MUL) begin
         acc_n = {mul_sum, acc[XL:1]};
      end else if (state == DIV) begin
         acc_n = {div_rem, acc[XL-1:0], div_ge};
      end
   end

   // Final sign correction and result selection
   always_comb begin
      prod = prod_neg ? -acc : acc;
      quo  = acc[XL:0];
      rem  = acc[2*XLEN-1:XLEN];
      case (cap_uop[2:0])
         3'd0:          mdu_result = prod[XL:0];
         3'd1, 3'd2,
         3'd3:          mdu_result = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:    mdu_result = quo_neg ? -quo : quo;
         default:       mdu_result = rem_neg ? -rem : rem;
      endcase
   end

   // FSM state register
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) state <= IDLE;
      else         state <= state_n;
   end

   // FSM next state; flush overrides everything
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (mdu_start) state_n = s3_uop[2] ? DIV : MUL;
         MUL, DIV: if (counter == 5'd0) state_n = FIN;
         default:  state_n = IDLE;
      endcase
      if (flush) state_n = IDLE;
   end

   // Iteration counter, operand capture and accumulator
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         counter   <= 5'd0;
         mag_b     <= '0;
         acc       <= '0;
         prod_neg  <= 1'b0;
         quo_neg   <= 1'b0;
         rem_neg   <= 1'b0;
         cap_rd    <= '0;
         cap_b     <= '0;
         cap_c     <= '0;
         cap_pc    <= '0;
         cap_uop   <= '0;
         cap_fu    <= '0;
         cap_trap  <= 1'b0;
         cap_size  <= '0;
         cap_instr <= '0;
      end else if (state == IDLE) begin
         if (mdu_start) begin
            counter   <= 5'(XLEN - 1);
            mag_b     <= in_mag_b;
            acc       <= {{XLEN{1'b0}}, in_mag_a};
            prod_neg  <= a_neg ^ b_neg;
            quo_neg   <= (a_neg ^ b_neg) && (s3_opr_b != '0);
            rem_neg   <= a_neg;
            cap_rd    <= s3_rd;
            cap_b     <= s3_opr_b;
            cap_c     <= s3_opr_c;
            cap_pc    <= s3_pc;
            cap_uop   <= s3_uop;
            cap_fu    <= s3_fu;
            cap_trap  <= s3_trap;
            cap_size  <= s3_size;
            cap_instr <= s3_instr;
         end
      end else if (state == MUL || state == DIV) begin
         acc <= acc_n;
         if (counter != 5'd0) counter <= counter - 5'd1;
      end
   end

   // s4 pipeline register: MDU result at FIN, pass-through on accept, hold under back-pressure
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         s4_p_valid <= 1'b0;
         s4_rd      <= '0;
         s4_result  <= '0;
         s4_opr_b   <= '0;
         s4_opr_c   <= '0;
         s4_pc      <= '0;
         s4_uop     <= '0;
         s4_fu      <= '0;
         s4_trap    <= 1'b0;
         s4_size    <= '0;
         s4_instr   <= '0;
      end else if (flush) begin
         s4_p_valid <= 1'b0;
      end else if (state == FIN) begin
         s4_p_valid <= 1'b1;
         s4_rd      <= cap_rd;
         s4_result  <= mdu_result;
         s4_opr_b   <= cap_b;
         s4_opr_c   <= cap_c;
         s4_pc      <= cap_pc;
         s4_uop     <= cap_uop;
         s4_fu      <= cap_fu;
         s4_trap    <= cap_trap;
         s4_size    <= cap_size;
         s4_instr   <= cap_instr;
      end else if (accept && !is_mdu) begin
         s4_p_valid <= 1'b1;
         s4_rd      <= s3_rd;
         s4_result  <= s3_opr_a;
         s4_opr_b   <= s3_opr_b;
         s4_opr_c   <= s3_opr_c;
         s4_pc      <= s3_pc;
         s4_uop     <= s3_uop;
         s4_fu      <= s3_fu;
         s4_trap    <= s3_trap;
         s4_size    <= s3_size;
         s4_instr   <= s3_instr;
      end else if (xfer_out) begin
         s4_p_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_frv_pipeline_mdu_stage.sv
// Directed bench for frv_pipeline_mdu_stage: pass-through, RV32M corners, back-pressure, flush, reset.
// Latency: checks 1-edge pass-through and 33-edge MDU completion.
// Backpressure: exercises s4_p_busy hold and same-edge drain plus accept.
module tb_frv_pipeline_mdu_stage;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        flush;
   logic        s3_p_valid;
   logic        s3_p_busy;
   logic [4:0]  s3_rd;
   logic [31:0] s3_opr_a;
   logic [31:0] s3_opr_b;
   logic [31:0] s3_opr_c;
   logic [31:0] s3_pc;
   logic [4:0]  s3_uop;
   logic [4:0]  s3_fu;
   logic        s3_trap;
   logic [1:0]  s3_size;
   logic [31:0] s3_instr;
   logic        s4_p_valid;
   logic        s4_p_busy;
   logic [4:0]  s4_rd;
   logic [31:0] s4_result;
   logic [31:0] s4_opr_b;
   logic [31:0] s4_opr_c;
   logic [31:0] s4_pc;
   logic [4:0]  s4_uop;
   logic [4:0]  s4_fu;
   logic        s4_trap;
   logic [1:0]  s4_size;
   logic [31:0] s4_instr;

   int total = 0;
   int bad   = 0;

   frv_pipeline_mdu_stage #(.XLEN(32)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
      .s3_p_valid(s3_p_valid), .s3_p_busy(s3_p_busy),
      .s3_rd(s3_rd), .s3_opr_a(s3_opr_a), .s3_opr_b(s3_opr_b), .s3_opr_c(s3_opr_c),
      .s3_pc(s3_pc), .s3_uop(s3_uop), .s3_fu(s3_fu), .s3_trap(s3_trap),
      .s3_size(s3_size), .s3_instr(s3_instr),
      .s4_p_valid(s4_p_valid), .s4_p_busy(s4_p_busy),
      .s4_rd(s4_rd), .s4_result(s4_result), .s4_opr_b(s4_opr_b), .s4_opr_c(s4_opr_c),
      .s4_pc(s4_pc), .s4_uop(s4_uop), .s4_fu(s4_fu), .s4_trap(s4_trap),
      .s4_size(s4_size), .s4_instr(s4_instr)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   // Offer one bundle for exactly one accepting edge
   task automatic issue(input logic [4:0] fu, input logic [4:0] uop,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(negedge g_clk);
      s3_fu = fu; s3_uop = uop; s3_opr_a = a; s3_opr_b = b; s3_opr_c = ~b; s3_rd = rd;
      s3_p_valid = 1'b1;
      @(posedge g_clk);
      #1;
      s3_p_valid = 1'b0;
   endtask

   // Issue an MDU op and check latency, busy duration, result and forwarded operand
   task automatic mdu_op(input string tag, input logic [4:0] uop,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
      int cyc;
      int bcnt;
      issue(5'b00010, uop, a, b, 5'd1 + {2'b00, uop[2:0]});
      bcnt = s3_p_busy ? 1 : 0;
      cyc  = 0;
      while (!s4_p_valid && cyc < 40) begin
         @(posedge g_clk);
         #1;
         cyc++;
         if (!s4_p_valid && s3_p_busy) bcnt++;
      end
      chk({tag, " lat"}, cyc, 33);
      chk({tag, " res"}, s4_result, expv);
      chk({tag, " busy"}, bcnt, 33);
      chk({tag, " oprb"}, s4_opr_b, b);
   endtask

   logic [31:0] pt_a [3];
   logic [4:0]  pt_rd [3];

   initial begin
      g_reset = 1'b0; flush = 1'b0; s3_p_valid = 1'b0; s4_p_busy = 1'b0;
      s3_rd = '0; s3_opr_a = '0; s3_opr_b = '0; s3_opr_c = '0; s3_pc = '0;
      s3_uop = '0; s3_fu = '0; s3_trap = 1'b0; s3_size = '0; s3_instr = '0;
      pt_a[0] = 32'h0000_1234; pt_a[1] = 32'hA5A5_0001; pt_a[2] = 32'hDEAD_BEEF;
      pt_rd[0] = 5'd5; pt_rd[1] = 5'd6; pt_rd[2] = 5'd7;

      // Reset state
      #2 g_reset = 1'b1;
      #1;
      chk("rst valid", s4_p_valid, 0);
      chk("rst result", s4_result, 0);
      chk("rst rd", s4_rd, 0);
      chk("rst busy", s3_p_busy, 0);
      chk("rst instr", s4_instr, 0);
      repeat (2) @(negedge g_clk);
      g_reset = 1'b0;

      // Back-to-back ALU pass-through, one per cycle
      for (int i = 0; i < 3; i++) begin
         @(negedge g_clk);
         s3_fu = 5'b00001; s3_uop = 5'd3; s3_opr_a = pt_a[i]; s3_opr_b = 32'h11 * (i + 1);
         s3_opr_c = 32'h0C0C; s3_rd = pt_rd[i]; s3_pc = 32'h100 + 4 * i;
         s3_instr = 32'h0000_0033; s3_size = 2'd2; s3_p_valid = 1'b1;
         @(posedge g_clk);
         #1;
         chk($sformatf("pt%0d valid", i), s4_p_valid, 1);
         chk($sformatf("pt%0d result", i), s4_result, pt_a[i]);
         chk($sformatf("pt%0d rd", i), s4_rd, pt_rd[i]);
         chk($sformatf("pt%0d pc", i), s4_pc, 32'h100 + 4 * i);
         chk($sformatf("pt%0d busy", i), s3_p_busy, 0);
      end
      chk("pt oprb", s4_opr_b, 32'h33);
      chk("pt instr", s4_instr, 32'h0000_0033);
      @(negedge g_clk);
      s3_p_valid = 1'b0;
      @(posedge g_clk);
      #1;
      chk("pt drain", s4_p_valid, 0);

      // Trapping MDU op passes straight through
      s3_trap = 1'b1;
      issue(5'b00010, 5'd4, 32'h55, 32'h2, 5'd9);
      chk("trap valid", s4_p_valid, 1);
      chk("trap result", s4_result, 32'h55);
      chk("trap flag", s4_trap, 1);
      s3_trap = 1'b0;

      // Multiply variants
      mdu_op("mul", 5'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      mdu_op("mulh", 5'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      mdu_op("mulhu", 5'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006);
      mdu_op("mulhsu", 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Divide corners
      mdu_op("div", 5'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      mdu_op("rem", 5'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      mdu_op("divu0", 5'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
      mdu_op("rem0", 5'd6, 32'd5, 32'd0, 32'd5);
      mdu_op("divovf", 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      mdu_op("removf", 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      chk("removf uop", s4_uop, 5'd6);

      // Back-pressure: hold result for 10 cycles, then drain and accept on one edge
      @(posedge g_clk);
      @(negedge g_clk);
      s4_p_busy = 1'b1;
      mdu_op("bp mul", 5'd0, 32'd6, 32'd7, 32'd42);
      for (int i = 0; i < 10; i++) begin
         @(posedge g_clk);
         #1;
         chk($sformatf("bp hold%0d", i), s4_result, 32'd42);
         chk($sformatf("bp busy%0d", i), s3_p_busy, 1);
      end
      chk("bp rd", s4_rd, 5'd1);
      @(negedge g_clk);
      s3_fu = 5'b00001; s3_opr_a = 32'h0000_CAFE; s3_rd = 5'd9; s3_p_valid = 1'b1;
      @(posedge g_clk);
      #1;
      chk("bp blocked", s4_result, 32'd42);
      @(negedge g_clk);
      s4_p_busy = 1'b0;
      @(posedge g_clk);
      #1;
      s3_p_valid = 1'b0;
      chk("bp new valid", s4_p_valid, 1);
      chk("bp new result", s4_result, 32'h0000_CAFE);
      chk("bp new rd", s4_rd, 5'd9);

      // Flush mid-divide
      issue(5'b00010, 5'd4, 32'd1000, 32'd7, 5'd3);
      repeat (15) @(posedge g_clk);
      @(negedge g_clk);
      flush = 1'b1;
      @(posedge g_clk);
      #1;
      flush = 1'b0;
      chk("flush valid", s4_p_valid, 0);
      chk("flush busy", s3_p_busy, 0);
      repeat (40) @(posedge g_clk);
      #1;
      chk("flush late valid", s4_p_valid, 0);
      mdu_op("post flush mul", 5'd0, 32'd3, 32'd4, 32'd12);

      // Asynchronous reset mid-multiply
      issue(5'b00010, 5'd0, 32'd9, 32'd9, 5'd4);
      repeat (10) @(posedge g_clk);
      #2 g_reset = 1'b1;
      #1;
      chk("arst result", s4_result, 0);
      chk("arst valid", s4_p_valid, 0);
      chk("arst busy", s3_p_busy, 0);
      chk("arst rd", s4_rd, 0);
      @(negedge g_clk);
      g_reset = 1'b0;
      mdu_op("post rst mul", 5'd0, 32'd2, 32'd2, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
